// File: rtl/nv_nvdla_cvif_write_cq.sv
`default_nettype none
// ============================================================================
//  Module      : nv_nvdla_cvif_write_cq
//  Description : CVIF write command queue. Five independent per-thread FIFOs
//                (bdma, sdp, pdp, cdp, rbk), each DEPTH x 3 bits, fed by one
//                shared write port and drained by five independent read ports.
//                Each entry holds {len[1:0], require_ack}.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DEPTH            entries per thread queue (power of two, 2..32)
//  Ports
//    nvdla_core_clk   in   1  clock, rising edge
//    nvdla_core_rstn  in   1  asynchronous active-low reset
//    cq_wr_pvld       in   1  write request valid
//    cq_wr_prdy       out  1  write accept (combinational, from flops + tid)
//    cq_wr_thread_id  in   3  target queue 0..4; 5..7 are dropped
//    cq_wr_pd         in   3  entry payload
//    cq_rdN_pvld      out  1  queue N non-empty            (N = 0..4)
//    cq_rdN_prdy      in   1  pop request for queue N      (N = 0..4)
//    cq_rdN_pd        out  3  head entry of queue N        (N = 0..4)
//    cq_idle          out  1  all queues empty
//    cq_wr_err        out  1  sticky: a write to thread 5..7 was accepted
// ============================================================================
module nv_nvdla_cvif_write_cq #(
    parameter int unsigned DEPTH = 8
) (
    input  logic       nvdla_core_clk,
    input  logic       nvdla_core_rstn,

    input  logic       cq_wr_pvld,
    output logic       cq_wr_prdy,
    input  logic [2:0] cq_wr_thread_id,
    input  logic [2:0] cq_wr_pd,

    output logic       cq_rd0_pvld,
    input  logic       cq_rd0_prdy,
    output logic [2:0] cq_rd0_pd,

    output logic       cq_rd1_pvld,
    input  logic       cq_rd1_prdy,
    output logic [2:0] cq_rd1_pd,

    output logic       cq_rd2_pvld,
    input  logic       cq_rd2_prdy,
    output logic [2:0] cq_rd2_pd,

    output logic       cq_rd3_pvld,
    input  logic       cq_rd3_prdy,
    output logic [2:0] cq_rd3_pd,

    output logic       cq_rd4_pvld,
    input  logic       cq_rd4_prdy,
    output logic [2:0] cq_rd4_pd,

    output logic       cq_idle,
    output logic       cq_wr_err
);

    localparam int unsigned     c_NTHR = 5;
    // Pointer width: DEPTH is a power of two, so pointers wrap naturally.
    localparam int unsigned     c_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Count width must hold the value DEPTH itself (full).
    localparam int unsigned     c_CW   = $clog2(DEPTH + 1);
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

    logic                    w_tid_legal;
    logic [7:0]              w_full;       // indexed directly by thread_id
    logic [c_NTHR-1:0]       w_push;
    logic [c_NTHR-1:0]       w_pop;
    logic [c_NTHR-1:0]       w_pvld;
    logic [c_NTHR-1:0]       w_rd_prdy;
    logic [c_NTHR-1:0][2:0]  w_rd_pd;
    logic                    r_wr_err;

    assign w_tid_legal = (cq_wr_thread_id <= 3'd4);
    assign w_rd_prdy   = {cq_rd4_prdy, cq_rd3_prdy, cq_rd2_prdy, cq_rd1_prdy, cq_rd0_prdy};

    // Ids 5..7 never have a queue behind them; tying their full bits low
    // makes cq_wr_prdy accept (and drop) those writes.
    assign w_full[7:5] = 3'b000;

    // Ready looks only at the registered occupancy, so a pop in the same
    // cycle does not open a slot for a write to a full queue.
    assign cq_wr_prdy = w_tid_legal ? ~w_full[cq_wr_thread_id] : 1'b1;

    // ------------------------------------------------------------------------
    // Per-thread FIFO
    // ------------------------------------------------------------------------
    for (genvar g = 0; g < c_NTHR; g++) begin : g_thr
        logic [c_AW-1:0] r_wp;
        logic [c_AW-1:0] r_rp;
        logic [c_CW-1:0] r_cnt;
        logic [2:0]      r_mem [DEPTH];

        assign w_pvld[g]  = (r_cnt != '0);
        assign w_full[g]  = (r_cnt == c_FULL);
        assign w_push[g]  = cq_wr_pvld & w_tid_legal &
                            (cq_wr_thread_id == 3'(g)) & ~w_full[g];
        // A pop request against an empty queue is simply ignored.
        assign w_pop[g]   = w_rd_prdy[g] & w_pvld[g];
        assign w_rd_pd[g] = r_mem[r_rp];

        always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
            if (!nvdla_core_rstn) begin
                r_wp  <= '0;
                r_rp  <= '0;
                r_cnt <= '0;
            end else begin
                if (w_push[g]) begin
                    r_wp <= r_wp + c_AW'(1);
                end
                if (w_pop[g]) begin
                    r_rp <= r_rp + c_AW'(1);
                end
                // Simultaneous push and pop leaves the count unchanged.
                case ({w_push[g], w_pop[g]})
                    2'b10:   r_cnt <= r_cnt + c_CW'(1);
                    2'b01:   r_cnt <= r_cnt - c_CW'(1);
                    default: r_cnt <= r_cnt;
                endcase
            end
        end

        // Payload storage is deliberately not reset; validity is carried
        // entirely by r_cnt, so stale contents are never presented as valid.
        always_ff @(posedge nvdla_core_clk) begin
            if (w_push[g]) begin
                r_mem[r_wp] <= cq_wr_pd;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Sticky illegal-thread flag
    // ------------------------------------------------------------------------
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_wr_err <= 1'b0;
        end else if (cq_wr_pvld & ~w_tid_legal) begin
            r_wr_err <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign cq_rd0_pvld = w_pvld[0];
    assign cq_rd1_pvld = w_pvld[1];
    assign cq_rd2_pvld = w_pvld[2];
    assign cq_rd3_pvld = w_pvld[3];
    assign cq_rd4_pvld = w_pvld[4];

    assign cq_rd0_pd   = w_rd_pd[0];
    assign cq_rd1_pd   = w_rd_pd[1];
    assign cq_rd2_pd   = w_rd_pd[2];
    assign cq_rd3_pd   = w_rd_pd[3];
    assign cq_rd4_pd   = w_rd_pd[4];

    assign cq_idle     = ~|w_pvld;
    assign cq_wr_err   = r_wr_err;

endmodule
`default_nettype wire

// File: tb/tb_nv_nvdla_cvif_write_cq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nv_nvdla_cvif_write_cq
//  Description : Directed self-checking bench for the CVIF write command
//                queue. Inputs change 1 time unit after the rising edge and
//                outputs are compared 1 time unit later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nv_nvdla_cvif_write_cq;

    localparam int unsigned DEPTH = 8;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic       cq_wr_pvld = 1'b0;
    logic       cq_wr_prdy;
    logic [2:0] cq_wr_thread_id = 3'd0;
    logic [2:0] cq_wr_pd = 3'd0;
    logic       cq_rd0_pvld, cq_rd1_pvld, cq_rd2_pvld, cq_rd3_pvld, cq_rd4_pvld;
    logic       cq_rd0_prdy = 1'b0, cq_rd1_prdy = 1'b0, cq_rd2_prdy = 1'b0;
    logic       cq_rd3_prdy = 1'b0, cq_rd4_prdy = 1'b0;
    logic [2:0] cq_rd0_pd, cq_rd1_pd, cq_rd2_pd, cq_rd3_pd, cq_rd4_pd;
    logic       cq_idle;
    logic       cq_wr_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    nv_nvdla_cvif_write_cq #(.DEPTH(DEPTH)) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .cq_wr_pvld      (cq_wr_pvld),
        .cq_wr_prdy      (cq_wr_prdy),
        .cq_wr_thread_id (cq_wr_thread_id),
        .cq_wr_pd        (cq_wr_pd),
        .cq_rd0_pvld     (cq_rd0_pvld),
        .cq_rd0_prdy     (cq_rd0_prdy),
        .cq_rd0_pd       (cq_rd0_pd),
        .cq_rd1_pvld     (cq_rd1_pvld),
        .cq_rd1_prdy     (cq_rd1_prdy),
        .cq_rd1_pd       (cq_rd1_pd),
        .cq_rd2_pvld     (cq_rd2_pvld),
        .cq_rd2_prdy     (cq_rd2_prdy),
        .cq_rd2_pd       (cq_rd2_pd),
        .cq_rd3_pvld     (cq_rd3_pvld),
        .cq_rd3_prdy     (cq_rd3_prdy),
        .cq_rd3_pd       (cq_rd3_pd),
        .cq_rd4_pvld     (cq_rd4_pvld),
        .cq_rd4_prdy     (cq_rd4_prdy),
        .cq_rd4_pd       (cq_rd4_pd),
        .cq_idle         (cq_idle),
        .cq_wr_err       (cq_wr_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_empty(input string tag);
        chk({tag, "_pvld"}, {cq_rd4_pvld, cq_rd3_pvld, cq_rd2_pvld, cq_rd1_pvld, cq_rd0_pvld}, 0);
        chk({tag, "_idle"}, cq_idle, 1);
    endtask

    logic [2:0] drain_exp [8];

    initial begin
        drain_exp = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6};

        // ---------------- reset state ----------------
        step();
        step();
        chk_all_empty("rst");
        chk("rst_err", cq_wr_err, 0);
        cq_wr_thread_id = 3'd4;
        #1;
        chk("rst_prdy_t4", cq_wr_prdy, 1);
        cq_wr_thread_id = 3'd7;
        #1;
        chk("rst_prdy_t7", cq_wr_prdy, 1);
        rstn = 1'b1;
        step();

        // ---------------- single entry on thread 1 ----------------
        cq_wr_pvld = 1'b1; cq_wr_thread_id = 3'd1; cq_wr_pd = 3'b101;
        #1;
        chk("single_prdy", cq_wr_prdy, 1);
        chk("single_pvld_T", cq_rd1_pvld, 0);
        step();
        cq_wr_pvld = 1'b0;
        #1;
        chk("single_pvld", cq_rd1_pvld, 1);
        chk("single_pd", cq_rd1_pd, 3'b101);
        chk("single_idle0", cq_idle, 0);
        cq_rd1_prdy = 1'b1;
        step();
        cq_rd1_prdy = 1'b0;
        #1;
        chk("single_pvld_pop", cq_rd1_pvld, 0);
        chk("single_idle1", cq_idle, 1);

        // ---------------- fill thread 4 ----------------
        for (int i = 0; i < 8; i++) begin
            cq_wr_pvld = 1'b1; cq_wr_thread_id = 3'd4; cq_wr_pd = 3'(i);
            #1;
            chk("fill_prdy", cq_wr_prdy, 1);
            step();
        end
        cq_wr_pd = 3'd6;
        #1;
        chk("full_prdy", cq_wr_prdy, 0);
        chk("full_pvld", cq_rd4_pvld, 1);
        chk("full_head", cq_rd4_pd, 0);
        step();                                  // rejected write
        cq_wr_pvld = 1'b0; cq_wr_thread_id = 3'd0;
        #1;
        chk("full_prdy_t0", cq_wr_prdy, 1);
        cq_wr_pvld = 1'b1; cq_wr_thread_id = 3'd4; cq_wr_pd = 3'd6; cq_rd4_prdy = 1'b1;
        #1;
        chk("full_no_passthru", cq_wr_prdy, 0);
        chk("full_head2", cq_rd4_pd, 0);
        step();                                  // pop of 0, write still rejected
        cq_rd4_prdy = 1'b0;
        #1;
        chk("full_prdy_back", cq_wr_prdy, 1);
        step();                                  // ninth entry (6) accepted
        cq_wr_pvld = 1'b0;
        cq_rd4_prdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("drain_pvld", cq_rd4_pvld, 1);
            chk("drain_pd", cq_rd4_pd, drain_exp[k]);
            step();
        end
        cq_rd4_prdy = 1'b0;
        #1;
        chk("drain_empty", cq_rd4_pvld, 0);

        // ---------------- wrap: push/pop pairs on thread 2 ----------------
        for (int i = 0; i <= 20; i++) begin
            cq_wr_pvld = (i < 20); cq_wr_thread_id = 3'd2; cq_wr_pd = 3'(i % 8);
            cq_rd2_prdy = (i > 0);
            #1;
            if (i > 0) begin
                chk("wrap_pvld", cq_rd2_pvld, 1);
                chk("wrap_pd", cq_rd2_pd, (i - 1) % 8);
            end
            if (i < 20) chk("wrap_prdy", cq_wr_prdy, 1);
            step();
        end
        cq_wr_pvld = 1'b0; cq_rd2_prdy = 1'b0;
        #1;
        chk_all_empty("wrap_end");

        // ---------------- pop while empty on thread 3 ----------------
        cq_rd3_prdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("epop_pvld", cq_rd3_pvld, 0);
            step();
        end
        cq_wr_pvld = 1'b1; cq_wr_thread_id = 3'd3; cq_wr_pd = 3'b010;
        step();
        cq_wr_pvld = 1'b0;
        #1;
        chk("epop_after_pvld", cq_rd3_pvld, 1);
        chk("epop_after_pd", cq_rd3_pd, 3'b010);
        step();
        cq_rd3_prdy = 1'b0;
        #1;
        chk("epop_consumed", cq_rd3_pvld, 0);

        // ---------------- illegal thread id ----------------
        cq_wr_pvld = 1'b1; cq_wr_thread_id = 3'd6; cq_wr_pd = 3'b111;
        #1;
        chk("ill_prdy", cq_wr_prdy, 1);
        chk("ill_err_T", cq_wr_err, 0);
        step();
        cq_wr_pvld = 1'b0;
        #1;
        chk("ill_err", cq_wr_err, 1);
        chk_all_empty("ill");
        step();
        step();
        chk("ill_err_held", cq_wr_err, 1);

        // ---------------- parallel pops on two threads ----------------
        cq_wr_pvld = 1'b1; cq_wr_thread_id = 3'd0; cq_wr_pd = 3'b001;
        step();
        cq_wr_thread_id = 3'd1; cq_wr_pd = 3'b010;
        step();
        cq_wr_pvld = 1'b0;
        #1;
        chk("par_pd0", cq_rd0_pd, 3'b001);
        chk("par_pd1", cq_rd1_pd, 3'b010);
        cq_rd0_prdy = 1'b1; cq_rd1_prdy = 1'b1;
        step();
        cq_rd0_prdy = 1'b0; cq_rd1_prdy = 1'b0;
        #1;
        chk_all_empty("par");

        // ---------------- reset mid-traffic ----------------
        for (int i = 1; i <= 3; i++) begin
            cq_wr_pvld = 1'b1; cq_wr_thread_id = 3'd0; cq_wr_pd = 3'(i);
            step();
        end
        for (int i = 1; i <= 5; i++) begin
            cq_wr_pvld = 1'b1; cq_wr_thread_id = 3'd3; cq_wr_pd = 3'(i);
            step();
        end
        cq_wr_pvld = 1'b0; cq_wr_thread_id = 3'd4;
        #1;
        chk("pre_rst_pvld0", cq_rd0_pvld, 1);
        chk("pre_rst_pvld3", cq_rd3_pvld, 1);
        chk("pre_rst_idle", cq_idle, 0);
        rstn = 1'b0;
        #1;
        chk_all_empty("async_rst");
        chk("async_rst_err", cq_wr_err, 0);
        chk("async_rst_prdy", cq_wr_prdy, 1);
        step();
        rstn = 1'b1;
        cq_wr_pvld = 1'b1; cq_wr_thread_id = 3'd0; cq_wr_pd = 3'b011;
        #1;
        chk("post_rst_prdy", cq_wr_prdy, 1);
        step();
        cq_wr_pvld = 1'b0;
        #1;
        chk("post_rst_pvld0", cq_rd0_pvld, 1);
        chk("post_rst_pd0", cq_rd0_pd, 3'b011);
        chk("post_rst_pvld3", cq_rd3_pvld, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
